// File: rtl/regf_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the register file.
interface regf_write_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              regwrite;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] write_data;
  logic              clear_busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  regwrite, wa, write_data, clear_busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output regwrite, wa, write_data, clear_busy
  );
endinterface

// File: rtl/regf_write_arbiter.sv
// Owns the register-file write port: zero-fill sweep after reset, then two-requester arbitration.
// Define REGF_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default build is round-robin.
module regf_write_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input logic               clk,
  input logic               reset,
  regf_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              regwrite_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] write_data_q;
  logic              clear_busy_q;
`ifndef REGF_ARB_FIXED_PRIO_EN
  logic              last_grant_q;
`endif

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StRun) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef REGF_ARB_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        // Tie goes to whoever did not win last time.
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
`endif
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign xfer      = grant0 | grant1;
  assign xfer_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign xfer_data = grant1 ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.regwrite   = regwrite_q;
  assign bus.wa         = wa_q;
  assign bus.write_data = write_data_q;
  assign bus.clear_busy = clear_busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StClear;
      clr_cnt_q    <= '0;
      regwrite_q   <= 1'b0;
      wa_q         <= '0;
      write_data_q <= '0;
      clear_busy_q <= 1'b1;
`ifndef REGF_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StClear: begin
          regwrite_q   <= 1'b1;
          wa_q         <= clr_cnt_q;
          write_data_q <= '0;
          clr_cnt_q    <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(NREGS - 1)) begin
            state_q      <= StRun;
            clear_busy_q <= 1'b0;
          end
        end
        StRun: begin
          // r0 is hardwired zero: accept the handshake but drop the write.
          regwrite_q <= xfer && (xfer_addr != '0);
          if (xfer && (xfer_addr != '0)) begin
            wa_q         <= xfer_addr;
            write_data_q <= xfer_data;
          end
`ifndef REGF_ARB_FIXED_PRIO_EN
          if (xfer) begin
            last_grant_q <= grant1;
          end
`endif
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: doc/regf_write_arbiter.md
Name: regf_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After reset, runs a clear sweep that writes zero to every register.
- Then shares the write port between two requesters: req0 (main writeback) and req1 (secondary/late-result unit), using valid/ready handshakes and round-robin arbitration.
- Drives the register file's regwrite/wa/write_data from registered outputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREGS, 32, registers swept by clear; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle (combinational).
- regwrite  out  1  register file write enable (registered).
- wa  out  ADDR_W  register file write address (registered).
- write_data  out  DATA_W  register file write data (registered).
- clear_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (async, active-high): regwrite=0, wa=0, write_data=0, clear_busy=1, state=CLEAR, clr_cnt=0, last_grant=1 (so req0 wins the first tie).
- Reset asserted mid-sweep or mid-run: everything returns to the reset state immediately; the sweep restarts from register 0.
- State CLEAR:
  - Each cycle: regwrite<=1, wa<=clr_cnt, write_data<=0, clr_cnt++.
  - When clr_cnt==NREGS-1 is issued: next state RUN, clear_busy<=0.
  - Sweep is exactly NREGS cycles of regwrite.
  - req0_ready=req1_ready=0 throughout. Requesters must hold valid/addr/data stable until ready.
- State RUN, one grant per cycle:
  - Only reqN_valid high: reqN_ready=1.
  - Both high: grant the requester that is not last_grant; then last_grant<=granted index.
  - Neither high: no grant; last_grant holds.
  - A transfer occurs when valid & ready in the same cycle.
  - The losing requester sees ready=0 and must hold its request.
- Write issue latency: 1 cycle. A transfer at edge N drives regwrite=1, wa=addr, write_data=data after edge N. With no transfer, regwrite<=0; wa and write_data hold their last values.
- Address 0 (hardwired zero register):
  - The handshake completes normally (ready=1).
  - regwrite<=0 for that cycle, so the write is dropped.
  - The grant still counts for round-robin.
- Back-to-back: a continuously valid single requester is accepted every cycle with full throughput.
- Two requesters to the same address in consecutive cycles: issued in grant order; the later write wins.
- ready never asserts when the matching valid is low.
- Both ready signals are never high in the same cycle.

Optional Feature:
- Macro REGF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. req0 always wins when both are valid; last_grant is unused.
- Undefined (default): round-robin as specified above.
- Clear sweep, latency and r0 drop are identical in both builds.

Test Plan:
- Reset, release, no requests -> clear_busy=1 for 32 cycles; regwrite=1 with wa=0..31 and write_data=0 in order; then clear_busy=0, regwrite=0.
- During CLEAR hold req0_valid=1, addr=5, data=0xDEADBEEF -> req0_ready=0 until RUN; accepted on the first RUN cycle; next cycle wa=5, write_data=0xDEADBEEF, regwrite=1.
- In RUN, both valid for 4 cycles (req0 addr=1, data=0x11; req1 addr=2, data=0x22), each holding until accepted -> grants 0,1 then 0x11 then 0x22 issued. Under REGF_ARB_FIXED_PRIO_EN -> req0 granted every cycle while valid.
- req1 valid with addr=0, data=0xFFFFFFFF -> req1_ready=1, regwrite stays 0.
- Reset asserted at sweep cycle 10 -> outputs go to reset values asynchronously; after release the sweep restarts at wa=0 and runs a full 32 cycles.
- req0 streams addr=3..7 on 5 consecutive cycles, req1 idle -> 5 consecutive regwrite pulses, wa=3..7, no bubbles.
